instr_fetch_unit: RTL and testbench

//  Fetch stage feeding control_path/datapath: holds PC, issues one request at a time to instruction memory,

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/instr_field_decode.sv | 21 ++
 rtl/instr_fetch_unit.sv | 112 +++++++++++
 tb/tb_instr_fetch_unit.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch-stage types, opcodes and instruction field positions
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;

    localparam int OPCODE_LSB = 0;
    localparam int RD_LSB     = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int FUNCT7_LSB = 25;

endpackage

// File: rtl/instr_field_decode.sv
// rtl/instr_field_decode.sv - combinational slicing of a 32-bit instruction into its fields
module instr_field_decode
    import fetch_pkg::*;
(
    input  logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  funct7
);

    assign opcode = instr[OPCODE_LSB +: 7];
    assign rd     = instr[RD_LSB     +: 5];
    assign funct3 = instr[FUNCT3_LSB +: 3];
    assign rs1    = instr[RS1_LSB    +: 5];
    assign rs2    = instr[RS2_LSB    +: 5];
    assign funct7 = instr[FUNCT7_LSB +: 7];

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - single-outstanding fetch stage with redirect flush and instruction register
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [6:0]        opcode,
    output logic [4:0]        rd,
    output logic [2:0]        funct3,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    output logic [6:0]        funct7
);

    fetch_state_e      state;
    logic [ADDR_W-1:0] pc;
    logic              drop;

    assign imem_req_valid = rst_n && (state == REQ);
    assign imem_addr      = pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= REQ;
            pc          <= RESET_PC;
            drop        <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (redirect_valid) begin
            // Redirect wins over every handshake; an accepted or pending fetch is marked stale.
            pc <= redirect_pc;
            case (state)
                REQ: begin
                    if (imem_req_ready) begin
                        state <= WAIT;
                        drop  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        state <= REQ;
                        drop  <= 1'b0;
                    end else begin
                        drop  <= 1'b1;
                    end
                end
                HOLD: begin
                    instr_valid <= 1'b0;
                    state       <= REQ;
                end
                default: state <= REQ;
            endcase
        end else begin
            case (state)
                REQ: begin
                    if (imem_req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= REQ;
                        end else begin
                            instr       <= imem_rsp_data;
                            instr_pc    <= pc;
                            pc          <= pc + ADDR_W'(PC_STEP);
                            instr_valid <= 1'b1;
                            state       <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

    instr_field_decode u_decode (
        .instr  (instr[31:0]),
        .opcode (opcode),
        .rd     (rd),
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .funct7 (funct7)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit with a latency-configurable imem model
module tb_instr_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;

    int checks = 0;
    int passes = 0;

    exp_t        sb[$];
    logic [31:0] exp_pc = '0;
    bit          ref_drop = 0;
    bit          busy = 0;
    int          cnt = 0;
    int          lat = 1;
    int          stall = 0;
    int          accepts = 0;
    int          transfers = 0;
    logic [31:0] req_addr = '0;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .opcode         (opcode),
        .rd             (rd),
        .funct3         (funct3),
        .rs1            (rs1),
        .rs2            (rs2),
        .funct7         (funct7)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return 32'h0020_8033 ^ {a[23:0], 8'h00};
    endfunction

    // imem model and reference PC tracking; runs after the stimulus tasks within each cycle
    always @(posedge clk) begin
        #4;
        imem_rsp_valid = 1'b0;
        if (!rst_n) begin
            busy     = 0;
            ref_drop = 0;
            exp_pc   = '0;
            sb.delete();
            imem_req_ready = (stall == 0);
        end else begin
            if (redirect_valid) exp_pc = redirect_pc;
            if (busy) begin
                if (cnt >= lat) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = data_of(req_addr);
                    busy = 0;
                    if (ref_drop || redirect_valid) begin
                        ref_drop = 0;
                    end else begin
                        sb.push_back('{exp_pc, data_of(exp_pc)});
                        exp_pc = exp_pc + 32'd4;
                    end
                end else begin
                    cnt++;
                    if (redirect_valid) ref_drop = 1;
                end
            end
            imem_req_ready = (stall == 0);
            if (stall > 0 && imem_req_valid) stall--;
            if (imem_req_valid && imem_req_ready) begin
                busy     = 1;
                cnt      = 1;
                req_addr = imem_addr;
                accepts++;
                if (redirect_valid) ref_drop = 1;
            end
        end
    end

    // Scoreboard consumer: every transfer must match the oldest expected instruction
    always @(posedge clk) begin
        exp_t e;
        #6;
        if (rst_n && instr_valid) begin
            if (redirect_valid) begin
                if (sb.size() > 0) e = sb.pop_front();
            end else if (instr_ready) begin
                transfers++;
                checks++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_transfer: got pc=%h instr=%h, expected no transfer (scoreboard empty)", instr_pc, instr);
                end else begin
                    e = sb.pop_front();
                    if (instr_pc !== e.pc || instr !== e.data)
                        $display("FAIL sb_transfer: got pc=%h instr=%h, expected pc=%h instr=%h", instr_pc, instr, e.pc, e.data);
                    else
                        passes++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_instr(output bit ok);
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (instr_valid) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic consume();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0)
            $display("FAIL reset_valids: got req_valid=%b instr_valid=%b, expected 0 0", imem_req_valid, instr_valid);
        else passes++;
        checks++;
        if (instr !== 32'h0 || instr_pc !== 32'h0 || imem_addr !== 32'h0)
            $display("FAIL reset_regs: got instr=%h instr_pc=%h addr=%h, expected all 0", instr, instr_pc, imem_addr);
        else passes++;
        checks++;
        if ({opcode, rd, funct3, rs1, rs2, funct7} !== 32'h0)
            $display("FAIL reset_fields: got %h, expected 0", {opcode, rd, funct3, rs1, rs2, funct7});
        else passes++;
    endtask

    task automatic test_basic_fetch();
        bit ok;
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0)
            $display("FAIL first_req: got valid=%b addr=%h, expected 1 00000000", imem_req_valid, imem_addr);
        else passes++;
        wait_instr(ok);
        checks++;
        if (!ok || instr !== 32'h0020_8033 || instr_pc !== 32'h0)
            $display("FAIL first_instr: got ok=%b instr=%h pc=%h, expected 1 00208033 00000000", ok, instr, instr_pc);
        else passes++;
        checks++;
        if (opcode !== 7'b0110011 || rd !== 5'd0 || rs1 !== 5'd1 || rs2 !== 5'd2 || funct3 !== 3'd0 || funct7 !== 7'd0)
            $display("FAIL first_fields: got op=%b rd=%0d f3=%0d rs1=%0d rs2=%0d f7=%0d, expected 0110011 0 0 1 2 0",
                     opcode, rd, funct3, rs1, rs2, funct7);
        else passes++;
        consume();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h4)
            $display("FAIL next_addr: got valid=%b addr=%h, expected 1 00000004", imem_req_valid, imem_addr);
        else passes++;
    endtask

    task automatic test_hold();
        bit ok;
        logic [31:0] a_instr, a_pc;
        int a_acc;
        bit stable = 1;
        wait_instr(ok);
        a_instr = instr;
        a_pc    = instr_pc;
        a_acc   = accepts;
        checks++;
        if (!ok || a_pc !== 32'h4)
            $display("FAIL hold_pc: got ok=%b pc=%h, expected 1 00000004", ok, a_pc);
        else passes++;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (instr !== a_instr || instr_pc !== a_pc || instr_valid !== 1'b1 || imem_req_valid !== 1'b0) stable = 0;
        end
        checks++;
        if (!stable || accepts != a_acc)
            $display("FAIL hold_stable: got stable=%b new_accepts=%0d, expected 1 0", stable, accepts - a_acc);
        else passes++;
        stall = 4;
        consume();
    endtask

    task automatic test_req_stall();
        bit ok;
        bit stable = 1;
        for (int i = 0; i < 4; i++) begin
            if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8) stable = 0;
            tick();
        end
        checks++;
        if (!stable)
            $display("FAIL stall_addr: got stable=%b, expected 1 (valid=1 addr=00000008)", stable);
        else passes++;
        wait_instr(ok);
        checks++;
        if (!ok || instr_pc !== 32'h8)
            $display("FAIL stall_instr: got ok=%b pc=%h, expected 1 00000008", ok, instr_pc);
        else passes++;
        consume();
    endtask

    task automatic test_redirect_wait();
        bit ok;
        bit seen_valid = 0;
        bit found = 0;
        lat = 2;
        tick();
        checks++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0)
            $display("FAIL wait_state: got req_valid=%b instr_valid=%b, expected 0 0", imem_req_valid, instr_valid);
        else passes++;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (instr_valid) seen_valid = 1;
            if (imem_req_valid) begin
                found = 1;
                break;
            end
            tick();
        end
        checks++;
        if (!found || seen_valid || imem_addr !== 32'h100)
            $display("FAIL redirect_wait: got found=%b seen_valid=%b addr=%h, expected 1 0 00000100", found, seen_valid, imem_addr);
        else passes++;
        lat = 1;
        wait_instr(ok);
        checks++;
        if (!ok || instr_pc !== 32'h100)
            $display("FAIL redirect_instr: got ok=%b pc=%h, expected 1 00000100", ok, instr_pc);
        else passes++;
    endtask

    task automatic test_redirect_hold();
        bit ok;
        int t0 = transfers;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        instr_ready    = 1'b1;
        tick();
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h200 || transfers != t0)
            $display("FAIL redirect_hold: got instr_valid=%b req_valid=%b addr=%h transfers=%0d, expected 0 1 00000200 0",
                     instr_valid, imem_req_valid, imem_addr, transfers - t0);
        else passes++;
        wait_instr(ok);
        checks++;
        if (!ok || instr_pc !== 32'h200)
            $display("FAIL hold_redirect_instr: got ok=%b pc=%h, expected 1 00000200", ok, instr_pc);
        else passes++;
        consume();
    endtask

    task automatic test_wrap_and_reset();
        bit ok;
        bit quiet = 1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        wait_instr(ok);
        checks++;
        if (!ok || instr_pc !== 32'hFFFF_FFFC)
            $display("FAIL wrap_instr: got ok=%b pc=%h, expected 1 fffffffc", ok, instr_pc);
        else passes++;
        consume();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0)
            $display("FAIL wrap_addr: got valid=%b addr=%h, expected 1 00000000", imem_req_valid, imem_addr);
        else passes++;
        wait_instr(ok);
        consume();
        tick();
        checks++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 32'h4)
            $display("FAIL pre_reset_wait: got req_valid=%b instr_valid=%b addr=%h, expected 0 0 00000004",
                     imem_req_valid, instr_valid, imem_addr);
        else passes++;
        rst_n = 1'b0;
        tick();
        checks++;
        if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0 || imem_addr !== 32'h0)
            $display("FAIL mid_reset: got instr_valid=%b req_valid=%b addr=%h, expected 0 0 00000000",
                     instr_valid, imem_req_valid, imem_addr);
        else passes++;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (imem_req_valid !== 1'b0) quiet = 0;
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (!quiet || imem_req_valid !== 1'b1 || imem_addr !== 32'h0)
            $display("FAIL post_reset: got quiet=%b valid=%b addr=%h, expected 1 1 00000000", quiet, imem_req_valid, imem_addr);
        else passes++;
        wait_instr(ok);
        checks++;
        if (!ok || instr_pc !== 32'h0)
            $display("FAIL post_reset_instr: got ok=%b pc=%h, expected 1 00000000", ok, instr_pc);
        else passes++;
        consume();
        tick();
        checks++;
        if (sb.size() != 0)
            $display("FAIL sb_drain: got %0d entries left, expected 0", sb.size());
        else passes++;
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_hold();
        test_req_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_wrap_and_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no completion by 50000, expected finish");
        $fatal(1, "timeout");
    end

endmodule
